tx_fifo_wr_ctrl: RTL

- Write-side scheduler for the TX async FIFO, in the write clock domain.
- Shares the single FIFO write port between two requesters: an 8-bit source (A, register-file read data) and a 16-bit source (B, ALU result, serialised as two bytes).
- Drives winc and write data, obeys wfull, arbitrates round-robin, and returns a one-cycle ack per completed transaction.

---
 rtl/tx_fifo_wr_ctrl_if.sv | 26 ++
 rtl/tx_fifo_wr_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/tx_fifo_wr_ctrl_if.sv
// Write-side bundle for the TX FIFO scheduler: requester A/B handshakes
// plus the FIFO write port and status.
interface tx_fifo_wr_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    a_req;
    logic [DATA_WIDTH-1:0]   a_data;
    logic                    a_ack;
    logic                    b_req;
    logic [2*DATA_WIDTH-1:0] b_data;
    logic                    b_ack;
    logic                    wfull;
    logic                    winc;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    busy;

    modport master (
        output a_req, a_data, b_req, b_data, wfull,
        input  a_ack, b_ack, winc, wr_data, busy
    );

    modport slave (
        input  a_req, a_data, b_req, b_data, wfull,
        output a_ack, b_ack, winc, wr_data, busy
    );
endinterface

// File: rtl/tx_fifo_wr_ctrl.sv
// TX FIFO write-port scheduler: round-robin between an 8-bit and a 16-bit source.
// Define TX_FIFO_WR_CTRL_HI_FIRST_EN to send the B high byte first.
module tx_fifo_wr_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input logic             wclk,
    input logic             wrst_n,
    tx_fifo_wr_ctrl_if.slave bus
);
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        SEND_A,
        SEND_B0,
        SEND_B1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [DW-1:0] b_keep_q, b_keep_d;
    logic          last_b_q, last_b_d;
    logic          a_ack_q, a_ack_d;
    logic          b_ack_q, b_ack_d;

    logic          winc;
    logic          a_elig;
    logic          b_elig;
    logic          pick_a;
    logic          pick_b;
    logic [DW-1:0] b_first;
    logic [DW-1:0] b_second;

`ifdef TX_FIFO_WR_CTRL_HI_FIRST_EN
    assign b_first  = bus.b_data[2*DW-1:DW];
    assign b_second = bus.b_data[DW-1:0];
`else
    assign b_first  = bus.b_data[DW-1:0];
    assign b_second = bus.b_data[2*DW-1:DW];
`endif

    assign winc = (state_q != IDLE) && !bus.wfull;

    // A requester whose ack is still visible is not eligible again yet.
    assign a_elig = bus.a_req && !a_ack_q;
    assign b_elig = bus.b_req && !b_ack_q;
    assign pick_a = a_elig && (!b_elig || last_b_q);
    assign pick_b = b_elig && !pick_a;

    always_comb begin
        state_d   = state_q;
        wr_data_d = wr_data_q;
        b_keep_d  = b_keep_q;
        last_b_d  = last_b_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    pick_a: begin
                        state_d   = SEND_A;
                        wr_data_d = bus.a_data;
                        last_b_d  = 1'b0;
                    end
                    pick_b: begin
                        state_d   = SEND_B0;
                        wr_data_d = b_first;
                        b_keep_d  = b_second;
                        last_b_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
            SEND_A: begin
                if (winc) begin
                    state_d = IDLE;
                    a_ack_d = 1'b1;
                end
            end
            SEND_B0: begin
                if (winc) begin
                    state_d   = SEND_B1;
                    wr_data_d = b_keep_q;
                end
            end
            SEND_B1: begin
                if (winc) begin
                    state_d = IDLE;
                    b_ack_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q   <= IDLE;
            wr_data_q <= '0;
            b_keep_q  <= '0;
            last_b_q  <= 1'b1;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_data_q <= wr_data_d;
            b_keep_q  <= b_keep_d;
            last_b_q  <= last_b_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
        end
    end

    assign bus.winc    = winc;
    assign bus.wr_data = wr_data_q;
    assign bus.a_ack   = a_ack_q;
    assign bus.b_ack   = b_ack_q;
    assign bus.busy    = (state_q != IDLE);
endmodule
